// File: rtl/ram_pkg.sv
// Shared definitions for the data-RAM access path: size codes, arbiter
// states and the byte-count helper used by range checking.
package ram_pkg;

  localparam logic [2:0] MEMC_B  = 3'd0;
  localparam logic [2:0] MEMC_H  = 3'd1;
  localparam logic [2:0] MEMC_W  = 3'd2;
  localparam logic [2:0] MEMC_BS = 3'd3;
  localparam logic [2:0] MEMC_HS = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Number of bytes touched by a size code; illegal codes count as one byte
  // so the range check still yields a sane end address.
  function automatic logic [2:0] access_bytes(input logic [2:0] memc);
    logic [2:0] n;
    n = 3'd1;
    if ((memc == MEMC_H) || (memc == MEMC_HS)) n = 3'd2;
    else if (memc == MEMC_W)                   n = 3'd4;
    return n;
  endfunction

endpackage

// File: rtl/ram_req_check.sv
// Combinational legality check for one RAM access: size code, store size,
// alignment and address range (end address on 33 bits to catch wrap-around).
module ram_req_check
  import ram_pkg::*;
#(
  parameter int ADDR_LIMIT = 256
) (
  input  logic        wmem_i,
  input  logic [2:0]  memc_i,
  input  logic [31:0] addr_i,
  output logic        err_o
);

  logic [32:0] end_addr;
  logic        bad_code;
  logic        bad_store;
  logic        bad_half;
  logic        bad_word;
  logic        bad_range;

  assign end_addr  = {1'b0, addr_i} + {30'd0, access_bytes(memc_i)} - 33'd1;
  assign bad_code  = (memc_i > MEMC_HS);
  assign bad_store = wmem_i & (memc_i > MEMC_W);
  assign bad_half  = ((memc_i == MEMC_H) || (memc_i == MEMC_HS)) & addr_i[0];
  assign bad_word  = (memc_i == MEMC_W) & (addr_i[1:0] != 2'b00);
  assign bad_range = (end_addr >= 33'(ADDR_LIMIT));

  // Any single violation rejects the access.
  always_comb begin
    err_o = bad_code | bad_store | bad_half | bad_word | bad_range;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port data RAM.
// Handshake: a request transfers on a rising edge where req_valid[p] and
// req_ready[p] are both high; req_ready depends only on state and req_valid,
// and only the request fields present at that edge are used. Responses are a
// one-cycle rsp_valid pulse with no backpressure.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_LIMIT = 256
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_wmem,
  input  logic [1:0][2:0]  req_memc,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             ram_wmem,
  output logic [2:0]       ram_memc,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  output logic [1:0]       dbg_state
);

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        grant_port;
  logic        accept;
  logic        sel_err;

  logic        lat_port_q;
  logic        lat_wmem_q;
  logic [2:0]  lat_memc_q;
  logic [31:0] lat_addr_q;
  logic [31:0] lat_wdata_q;
  logic        lat_err_q;
  logic [31:0] rsp_rdata_q;

  // Pick the candidate port: a lone valid port wins, a tie goes to the port
  // not granted last.
  always_comb begin
    grant_port = 1'b0;
    case (req_valid)
      2'b11:   grant_port = ~last_grant_q;
      2'b10:   grant_port = 1'b1;
      default: grant_port = 1'b0;
    endcase
  end

  ram_req_check #(
    .ADDR_LIMIT (ADDR_LIMIT)
  ) u_check (
    .wmem_i (req_wmem[grant_port]),
    .memc_i (req_memc[grant_port]),
    .addr_i (req_addr[grant_port]),
    .err_o  (sel_err)
  );

  // Next-state and handshake logic; requests are only taken in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid[grant_port]) begin
          req_ready[grant_port] = 1'b1;
          accept                = 1'b1;
          state_d               = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and round-robin pointer (port 0 wins the first tie).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) last_grant_q <= grant_port;
    end
  end

  // Capture the winning request at handshake; holds until the next accept.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lat_port_q  <= 1'b0;
      lat_wmem_q  <= 1'b0;
      lat_memc_q  <= 3'd0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= 32'd0;
      lat_err_q   <= 1'b0;
    end else if (accept) begin
      lat_port_q  <= grant_port;
      lat_wmem_q  <= req_wmem[grant_port];
      lat_memc_q  <= req_memc[grant_port];
      lat_addr_q  <= req_addr[grant_port];
      lat_wdata_q <= req_wdata[grant_port];
      lat_err_q   <= sel_err;
    end
  end

  // Capture load data at the end of ACCESS; stores and errors return zero.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rsp_rdata_q <= 32'd0;
    end else if (state_q == ACCESS) begin
      rsp_rdata_q <= (lat_wmem_q | lat_err_q) ? 32'd0 : ram_rdata;
    end
  end

  // The write strobe is decoded from state so an asynchronous reset drops it
  // at once, and it is masked by err so a rejected access never writes.
  assign ram_wmem  = (state_q == ACCESS) & lat_wmem_q & ~lat_err_q;
  assign ram_memc  = (state_q == ACCESS) ? lat_memc_q : 3'd0;
  assign ram_addr  = lat_addr_q;
  assign ram_wdata = lat_wdata_q;

  assign rsp_valid = (state_q != RESP) ? 2'b00 : (lat_port_q ? 2'b10 : 2'b01);
  assign rsp_err   = (state_q == RESP) & lat_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-addressed RAM model behind it.
module tb_ram_arbiter;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_wmem;
  logic [1:0][2:0]  req_memc;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             ram_wmem;
  logic [2:0]       ram_memc;
  logic [31:0]      ram_addr;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;
  logic [1:0]       dbg_state;

  int n_asserts = 0;
  int n_fail    = 0;
  int wmem_cycles = 0;

  logic [7:0] mem [0:255];
  logic [7:0] b0, b1, b2, b3;

  ram_arbiter #(.ADDR_LIMIT(256)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wmem  (req_wmem),
    .req_memc  (req_memc),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_wmem  (ram_wmem),
    .ram_memc  (ram_memc),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 CLK = ~CLK;

  // RAM model: combinational read with sign/zero extension, write on clock.
  assign b0 = mem[ram_addr[7:0]];
  assign b1 = mem[8'(ram_addr[7:0] + 8'd1)];
  assign b2 = mem[8'(ram_addr[7:0] + 8'd2)];
  assign b3 = mem[8'(ram_addr[7:0] + 8'd3)];

  always_comb begin
    ram_rdata = {b3, b2, b1, b0};
    case (ram_memc)
      3'd0: ram_rdata = {24'd0, b0};
      3'd3: ram_rdata = {{24{b0[7]}}, b0};
      3'd1: ram_rdata = {16'd0, b1, b0};
      3'd4: ram_rdata = {{16{b1[7]}}, b1, b0};
      default: ram_rdata = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge CLK) begin
    if (ram_wmem === 1'b1) begin
      mem[ram_addr[7:0]] = ram_wdata[7:0];
      if (ram_memc == 3'd1 || ram_memc == 3'd2)
        mem[8'(ram_addr[7:0] + 8'd1)] = ram_wdata[15:8];
      if (ram_memc == 3'd2) begin
        mem[8'(ram_addr[7:0] + 8'd2)] = ram_wdata[23:16];
        mem[8'(ram_addr[7:0] + 8'd3)] = ram_wdata[31:24];
      end
    end
  end

  always @(negedge CLK) begin
    if (ram_wmem === 1'b1) wmem_cycles++;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction from a single port, checked through every phase.
  task automatic do_req(input string tag, input int port, input logic wmem,
                        input logic [2:0] memc, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int   w0;
    logic got;
    logic exp_wmem;
    exp_wmem = wmem & ~exp_err;
    @(negedge CLK);
    req_valid[port] = 1'b1;
    req_wmem[port]  = wmem;
    req_memc[port]  = memc;
    req_addr[port]  = addr;
    req_wdata[port] = wdata;
    #1;
    got = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (req_ready[port] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge CLK); #1;
    end
    chk({tag, " ready"}, {31'd0, got}, 32'd1);
    w0 = wmem_cycles;
    @(posedge CLK); #1;
    req_valid[port] = 1'b0;
    req_addr[port]  = $urandom;
    req_wdata[port] = $urandom;
    req_memc[port]  = 3'($urandom_range(0, 7));
    @(negedge CLK);
    chk({tag, " state"}, {30'd0, dbg_state}, 32'd1);
    chk({tag, " wmem"}, {31'd0, ram_wmem}, {31'd0, exp_wmem});
    chk({tag, " memc"}, {29'd0, ram_memc}, {29'd0, memc});
    chk({tag, " addr"}, ram_addr, addr);
    @(negedge CLK);
    chk({tag, " rsp_valid"}, {30'd0, rsp_valid}, (port == 0) ? 32'd1 : 32'd2);
    chk({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    chk({tag, " rdata"}, rsp_rdata, exp_rdata);
    @(negedge CLK); #1;
    chk({tag, " rsp_done"}, {30'd0, rsp_valid}, 32'd0);
    chk({tag, " wmem_count"}, wmem_cycles - w0, exp_wmem ? 32'd1 : 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    req_valid = 2'b00;
    req_wmem  = 2'b00;
    req_memc  = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state
    #12;
    chk("rst req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst ram_wmem", {31'd0, ram_wmem}, 32'd0);
    chk("rst ram_memc", {29'd0, ram_memc}, 32'd0);
    chk("rst ram_addr", ram_addr, 32'd0);
    chk("rst ram_wdata", ram_wdata, 32'd0);
    chk("rst state", {30'd0, dbg_state}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // Word store then load
    do_req("st_w", 0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    do_req("ld_w", 0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Signed / unsigned half load of bytes 0x34, 0x80
    do_req("st_b0", 1, 1'b1, 3'd0, 32'h20, 32'hAABBCC34, 32'd0, 1'b0);
    do_req("st_b1", 1, 1'b1, 3'd0, 32'h21, 32'hAABBCC80, 32'd0, 1'b0);
    chk("byte_only", {24'd0, mem[8'h22]}, 32'd0);
    do_req("ld_hs", 1, 1'b0, 3'd4, 32'h20, 32'h0, 32'hFFFF8034, 1'b0);
    do_req("ld_h", 1, 1'b0, 3'd1, 32'h20, 32'h0, 32'h00008034, 1'b0);
    do_req("ld_bs", 1, 1'b0, 3'd3, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);

    // Contention: both ports valid for six grants; last grant was port 1
    @(negedge CLK);
    req_valid = 2'b11;
    req_wmem  = 2'b00;
    req_memc[0] = 3'd2; req_addr[0] = 32'h10;
    req_memc[1] = 3'd1; req_addr[1] = 32'h20;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rr ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge CLK);
      @(negedge CLK);
      chk("rr access_ready", {30'd0, req_ready}, 32'd0);
      @(negedge CLK);
      chk("rr rsp_valid", {30'd0, rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr rdata", rsp_rdata, (i % 2 == 0) ? 32'hDEADBEEF : 32'h00008034);
      chk("rr resp_ready", {30'd0, req_ready}, 32'd0);
      @(negedge CLK); #1;
    end
    req_valid = 2'b00;

    // Error cases and range boundaries
    do_req("err_unal_st", 0, 1'b1, 3'd2, 32'h12, 32'h11223344, 32'd0, 1'b1);
    do_req("err_st_bs", 0, 1'b1, 3'd3, 32'h14, 32'h55667788, 32'd0, 1'b1);
    do_req("err_range", 0, 1'b0, 3'd2, 32'hFE, 32'h0, 32'd0, 1'b1);
    do_req("err_code", 1, 1'b0, 3'd5, 32'h0, 32'h0, 32'd0, 1'b1);
    do_req("err_wrap", 1, 1'b0, 3'd0, 32'hFFFFFFFF, 32'h0, 32'd0, 1'b1);
    do_req("err_half_odd", 0, 1'b1, 3'd1, 32'h21, 32'hFFFF, 32'd0, 1'b1);
    do_req("ok_top_b", 0, 1'b0, 3'd0, 32'hFF, 32'h0, 32'd0, 1'b0);
    do_req("ok_top_w", 1, 1'b0, 3'd2, 32'hFC, 32'h0, 32'd0, 1'b0);
    chk("err mem10", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
    chk("err mem14", {mem[8'h17], mem[8'h16], mem[8'h15], mem[8'h14]}, 32'd0);
    chk("err mem20", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h00008034);

    // Reset during a store's ACCESS cycle
    @(negedge CLK);
    req_valid[0] = 1'b1; req_wmem[0] = 1'b1; req_memc[0] = 3'd2;
    req_addr[0] = 32'h30; req_wdata[0] = 32'hCAFEF00D;
    #1;
    chk("mid ready", {30'd0, req_ready}, 32'd1);
    @(posedge CLK); #1;
    req_valid[0] = 1'b0;
    @(negedge CLK);
    chk("mid wmem_before", {31'd0, ram_wmem}, 32'd1);
    #1 RESET = 1'b0;
    #1;
    chk("mid wmem_drop", {31'd0, ram_wmem}, 32'd0);
    chk("mid state", {30'd0, dbg_state}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("mid no_write", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'd0);
    chk("mid no_rsp", {30'd0, rsp_valid}, 32'd0);
    @(negedge CLK);
    req_valid = 2'b11; req_wmem = 2'b00;
    req_memc[0] = 3'd2; req_addr[0] = 32'h30;
    req_memc[1] = 3'd4; req_addr[1] = 32'h20;
    RESET = 1'b1;
    #1;
    chk("post_rst tie", {30'd0, req_ready}, 32'd1);
    @(posedge CLK); #1;
    req_valid = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    chk("post_rst rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("post_rst rdata", rsp_rdata, 32'd0);
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
